sd_spi_byte_engine: RTL and testbench

- SPI mode-0 byte transport sitting directly downstream of the SD card initialisation sequencer and, after init, the block-read/write controllers.
- Consumes the sequencer's byte stream (startflag/send_data/recv_num/init_CS) and drives SCLK/MOSI/CS to the card.
- Returns response bytes using the start_send/recv_valid handshake.
- Handles R1 start-bit hunting, multi-byte (R3/R7) response capture and response timeout.

---
 rtl/sd_spi_byte_engine_pkg.sv | 26 ++
 rtl/sd_spi_clkdiv.sv | 47 ++++
 rtl/sd_spi_byte_engine.sv | 169 ++++++++++++++++
 tb/tb_sd_spi_byte_engine.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_byte_engine_pkg.sv
// Shared SD-over-SPI definitions: FSM encodings, R1 constants, fill byte, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_spi_byte_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] R1_IDLE   = 8'h01;
    localparam logic [7:0] R1_READY  = 8'h00;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    localparam int DEF_DIV      = 1;
    localparam int DEF_HUNT_MAX = 16;
    localparam int DEF_CMD_LEN  = 6;

    // An R1 token is recognised by its leading zero bit; the card idles MISO high.
    function automatic logic r1_start_bit(input logic [7:0] b);
        return ~b[7];
    endfunction

endpackage

// File: rtl/sd_spi_clkdiv.sv
// SCLK generator: toggles SCLK every DIV enabled cycles, flags the edge about to happen.
// Latency: first rising edge DIV cycles after en_i rises; ticks are combinational.
// Backpressure: none; dropping en_i returns SCLK low and restarts the count.
//
// Ports:
//   CLK, RST      system clock, async active-low reset
//   en_i          run the divider (held for the whole byte)
//   sclk_o        registered SPI clock, idle low
//   rise_tick_o   high in the cycle whose closing edge raises sclk_o
//   fall_tick_o   high in the cycle whose closing edge lowers sclk_o
module sd_spi_clkdiv #(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    localparam logic [7:0] HALF_LAST = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic       sclk_q;
    logic       half_done;

    assign half_done   = en_i && (cnt_q == HALF_LAST);
    assign rise_tick_o = half_done && !sclk_q;
    assign fall_tick_o = half_done &&  sclk_q;
    assign sclk_o      = sclk_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else if (half_done) begin
            cnt_q  <= 8'd0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 byte engine for SD cards: byte transfer, R1 hunt, multi-byte response, hunt timeout.
// Latency: start_send 1 cycle after startflag seen in IDLE; byte period 16*DIV+2 cycles.
// Backpressure: upstream paces via start_send; recv_valid/timeout are unconditioned pulses.
//
// Ports:
//   CLK, RST                   system clock, async active-low reset
//   startflag                  keep transferring bytes while high
//   send_data / start_send     next TX byte, latched in the start_send cycle
//   recv_num                   extra response bytes following R1
//   force_cs                   hold CS high (dummy clocks)
//   MISO / SCLK / MOSI / CS    card interface
//   recv_valid / recv_data     response byte pulse and data
//   timeout                    hunt gave up (with recv_valid, data FF)
//   busy                       engine not idle
module sd_spi_byte_engine
    import sd_spi_byte_engine_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int HUNT_MAX = DEF_HUNT_MAX,
    parameter int CMD_LEN  = DEF_CMD_LEN
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       startflag,
    input  logic [7:0] send_data,
    input  logic [9:0] recv_num,
    input  logic       force_cs,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS,
    output logic       start_send,
    output logic       recv_valid,
    output logic [7:0] recv_data,
    output logic       timeout,
    output logic       busy
);
    localparam int CNT_MAX = CMD_LEN + HUNT_MAX;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_TMO = CW'(CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(CMD_LEN);

    state_e        state_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic [2:0]    bit_q;
    logic [CW-1:0] bcnt_q;
    logic          hunt_done_q;
    logic [9:0]    rem_q;
    logic          mosi_q;
    logic          start_send_q;
    logic          recv_valid_q;
    logic          timeout_q;
    logic [7:0]    recv_data_q;

    logic shift_en;
    logic rise_tick;
    logic fall_tick;
    logic hunting;

    assign shift_en = (state_q == ST_SHIFT);

    sd_spi_clkdiv #(
        .DIV(DIV)
    ) u_clkdiv (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (shift_en),
        .sclk_o     (SCLK),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    // bcnt_q is the number of bytes already finished, so byte CMD_LEN+1 is the first hunted one.
    assign hunting = !hunt_done_q && (bcnt_q >= CNT_ARM);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            tx_q         <= FILL_BYTE;
            rx_q         <= FILL_BYTE;
            bit_q        <= 3'd0;
            bcnt_q       <= '0;
            hunt_done_q  <= 1'b0;
            rem_q        <= 10'd0;
            mosi_q       <= 1'b1;
            start_send_q <= 1'b0;
            recv_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            recv_data_q  <= FILL_BYTE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mosi_q      <= 1'b1;
                    bcnt_q      <= '0;
                    hunt_done_q <= 1'b0;
                    rem_q       <= 10'd0;
                    if (startflag) begin
                        state_q      <= ST_LOAD;
                        start_send_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    start_send_q <= 1'b0;
                    tx_q         <= send_data;
                    mosi_q       <= send_data[7];
                    bit_q        <= 3'd0;
                    state_q      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (rise_tick) begin
                        rx_q <= {rx_q[6:0], MISO};
                    end
                    if (fall_tick) begin
                        tx_q   <= {tx_q[6:0], 1'b1};
                        mosi_q <= tx_q[6];
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            // rx_q is complete after the 8th rise, so the response
                            // decision is registered here and shows up during DONE,
                            // keeping recv_valid clear of the following LOAD pulse.
                            mosi_q  <= 1'b1;
                            state_q <= ST_DONE;
                            if (bcnt_q != CNT_SAT) begin
                                bcnt_q <= bcnt_q + CW'(1);
                            end
                            if (hunting && r1_start_bit(rx_q)) begin
                                recv_valid_q <= 1'b1;
                                recv_data_q  <= rx_q;
                                rem_q        <= recv_num;
                                hunt_done_q  <= 1'b1;
                            end else if (rem_q != 10'd0) begin
                                recv_valid_q <= 1'b1;
                                recv_data_q  <= rx_q;
                                rem_q        <= rem_q - 10'd1;
                            end else if (hunting && (bcnt_q == CNT_TMO)) begin
                                recv_valid_q <= 1'b1;
                                timeout_q    <= 1'b1;
                                recv_data_q  <= FILL_BYTE;
                                hunt_done_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    recv_valid_q <= 1'b0;
                    timeout_q    <= 1'b0;
                    if (startflag) begin
                        state_q      <= ST_LOAD;
                        start_send_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign MOSI       = mosi_q;
    assign CS         = force_cs | (state_q == ST_IDLE);
    assign start_send = start_send_q;
    assign recv_valid = recv_valid_q;
    assign recv_data  = recv_data_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Bench for sd_spi_byte_engine (DIV=2): directed byte streams, card model, response scoreboard.
// Latency: byte period 34 cycles at DIV=2.
// Backpressure: stimulus follows start_send; monitor pops expected responses on recv_valid.
module tb_sd_spi_byte_engine;

    localparam int BYTE_CYC = 34;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       startflag = 1'b0;
    logic [7:0] send_data = 8'hFF;
    logic [9:0] recv_num = 10'd0;
    logic       force_cs = 1'b0;
    logic       MISO = 1'b1;
    logic       SCLK, MOSI, CS, start_send, recv_valid, timeout, busy;
    logic [7:0] recv_data;

    sd_spi_byte_engine #(.DIV(2), .HUNT_MAX(16), .CMD_LEN(6)) dut (
        .CLK(CLK), .RST(RST), .startflag(startflag), .send_data(send_data),
        .recv_num(recv_num), .force_cs(force_cs), .MISO(MISO), .SCLK(SCLK),
        .MOSI(MOSI), .CS(CS), .start_send(start_send), .recv_valid(recv_valid),
        .recv_data(recv_data), .timeout(timeout), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       to;
        int         idx;
        int         gap;   // 0 = spacing not checked
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_exp[$];
    logic [7:0] miso_q[$];
    logic [7:0] tx_tbl[32];
    logic [7:0] rx_tbl[32];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_rise   = 0;
    int n_ss     = 0;
    int n_cslow  = 0;
    int byte_no  = 0;
    int last_rv  = 0;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Response / MOSI monitor.
    initial begin : monitor
        logic       sclk_prev;
        logic [7:0] mo;
        int         nbit;
        exp_t       e;
        sclk_prev = 1'b0; mo = 8'h00; nbit = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                sclk_prev = 1'b0; nbit = 0; byte_no = 0;
            end else begin
                if (start_send) begin n_ss++; byte_no++; end
                if (!busy) byte_no = 0;
                if (!CS) n_cslow++;
                if (SCLK && !sclk_prev) begin
                    n_rise++;
                    mo = {mo[6:0], MOSI};
                    nbit++;
                    if (nbit == 8) begin
                        nbit = 0;
                        if (tx_exp.size() == 0) begin
                            n_checks++;
                            $display("FAIL mosi_byte: got byte %h, required no byte", mo);
                        end else check("mosi_byte", mo, tx_exp.pop_front());
                    end
                end
                if (recv_valid) begin
                    check("recv_vs_start_send", start_send, 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_recv: got data %h timeout %b, required no recv_valid",
                                 recv_data, timeout);
                    end else begin
                        e = exp_q.pop_front();
                        check("recv_data", recv_data, e.d);
                        check("recv_timeout", timeout, e.to);
                        check("recv_byte_no", byte_no, e.idx);
                        if (e.gap != 0) check("recv_gap", cyc - last_rv, e.gap);
                    end
                    last_rv = cyc;
                end else if (timeout) begin
                    n_checks++;
                    $display("FAIL stray_timeout: got timeout=1 without recv_valid, required 0");
                end
                sclk_prev = SCLK;
            end
        end
    end

    // Card model: presents each byte MSB first, next bit after every SCLK rise.
    initial begin : card
        logic       prev;
        logic [7:0] cb;
        int         nr;
        prev = 1'b0; cb = 8'hFF; nr = 8;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prev = 1'b0; nr = 8; MISO = 1'b1;
            end else begin
                if (start_send) begin
                    cb = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hFF;
                    nr = 0;
                    MISO = cb[7];
                end else if (SCLK && !prev) begin
                    nr++;
                    MISO = (nr < 8) ? cb[7 - nr] : 1'b1;
                end
                prev = SCLK;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_ss(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            if (start_send) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_checks++; $display("FAIL start_send_wait: got no pulse, required one"); end
    endtask

    task automatic wait_idle(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK); #1;
            if (!busy) begin at = cyc; break; end
        end
        if (at < 0) begin n_checks++; $display("FAIL idle_wait: got busy=1, required 0"); end
    endtask

    task automatic wait_rises(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            if (n_rise >= target) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_checks++; $display("FAIL rise_wait: got %0d rises, required %0d", n_rise, target); end
    endtask

    // Streams n bytes from tx_tbl, card answers from rx_tbl; drops startflag after the last load.
    task automatic run_bytes(input int n);
        bit ok;
        int t;
        for (int i = 0; i < n; i++) begin
            tx_exp.push_back(tx_tbl[i]);
            miso_q.push_back(rx_tbl[i]);
        end
        @(posedge CLK); #1;
        send_data = tx_tbl[0];
        startflag = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_ss(ok);
            if (!ok) break;
            @(posedge CLK); #1;
            if (i + 1 < n) send_data = tx_tbl[i + 1];
            else startflag = 1'b0;
        end
        startflag = 1'b0;
        wait_idle(t);
        check("exp_drained", exp_q.size(), 0);
        check("tx_drained", tx_exp.size(), 0);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic to, input int idx, input int gap);
        exp_t e;
        e.d = d; e.to = to; e.idx = idx; e.gap = gap;
        exp_q.push_back(e);
    endtask

    initial begin : stim
        bit ok;
        int r0, s0, ss_c, t_idle;
        logic [7:0] cmd8[6];
        logic [7:0] r7[5];

        // Reset state.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_cs", CS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 1);
        check("rst_start_send", start_send, 0);
        check("rst_recv_valid", recv_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_recv_data", recv_data, 8'hFF);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        // Single 0x40 byte: first-pulse latency, CS, 8 rises, byte period.
        tx_exp.push_back(8'h40);
        miso_q.push_back(8'hFF);
        r0 = n_rise;
        @(posedge CLK); #1;
        send_data = 8'h40;
        startflag = 1'b1;
        check("t1_idle_no_pulse", start_send, 0);
        @(posedge CLK); #1;
        check("t1_start_send_cycle1", start_send, 1);
        check("t1_cs_low_cycle1", CS, 0);
        ss_c = cyc;
        @(posedge CLK); #1;
        startflag = 1'b0;
        wait_idle(t_idle);
        check("t1_byte_period", t_idle - ss_c, BYTE_CYC);
        check("t1_rises", n_rise - r0, 8);
        check("t1_cs_after_done", CS, 1);
        check("t1_tx_drained", tx_exp.size(), 0);

        // CMD0 frame, R1 = 0x01 on byte 9.
        cmd8 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        for (int i = 0; i < 9; i++) begin
            tx_tbl[i] = (i < 6) ? cmd8[i] : 8'hFF;
            rx_tbl[i] = 8'hFF;
        end
        rx_tbl[8] = 8'h01;
        recv_num = 10'd0;
        push_exp(8'h01, 1'b0, 9, 0);
        run_bytes(9);

        // CMD8 frame, R7 response with 4 trailing bytes, 34 cycles apart.
        cmd8 = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
        r7 = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        for (int i = 0; i < 11; i++) begin
            tx_tbl[i] = (i < 6) ? cmd8[i] : 8'hFF;
            rx_tbl[i] = (i < 6) ? 8'hFF : r7[i - 6];
            push_exp(8'h00, 1'b0, 0, 0);
            void'(exp_q.pop_back());
        end
        recv_num = 10'd4;
        for (int i = 0; i < 5; i++) push_exp(r7[i], 1'b0, 7 + i, (i == 0) ? 0 : BYTE_CYC);
        run_bytes(11);
        recv_num = 10'd0;

        // Dummy clocks with CS forced high.
        force_cs = 1'b1;
        for (int i = 0; i < 10; i++) begin tx_tbl[i] = 8'hFF; rx_tbl[i] = 8'hFF; end
        r0 = n_rise; s0 = n_ss; n_cslow = 0;
        run_bytes(10);
        check("fcs_rises", n_rise - r0, 80);
        check("fcs_start_sends", n_ss - s0, 10);
        check("fcs_cs_low_cycles", n_cslow, 0);
        force_cs = 1'b0;

        // Hunt timeout on byte 22, silence afterwards.
        for (int i = 0; i < 25; i++) begin tx_tbl[i] = 8'hFF; rx_tbl[i] = 8'hFF; end
        push_exp(8'hFF, 1'b1, 22, 0);
        run_bytes(25);

        // startflag dropped at bit 3.
        tx_exp.push_back(8'hA5);
        miso_q.push_back(8'hFF);
        r0 = n_rise; s0 = n_ss;
        @(posedge CLK); #1;
        send_data = 8'hA5;
        startflag = 1'b1;
        wait_ss(ok);
        ss_c = cyc;
        wait_rises(r0 + 3);
        startflag = 1'b0;
        wait_idle(t_idle);
        check("drop_byte_period", t_idle - ss_c, BYTE_CYC);
        check("drop_rises", n_rise - r0, 8);
        check("drop_start_sends", n_ss - s0, 1);
        check("drop_cs_after_done", CS, 1);

        // Reset at bit 3 aborts immediately.
        tx_exp.push_back(8'h00);
        miso_q.push_back(8'hFF);
        r0 = n_rise;
        @(posedge CLK); #1;
        send_data = 8'h00;
        startflag = 1'b1;
        wait_ss(ok);
        wait_rises(r0 + 3);
        check("pre_rst_sclk", SCLK, 1);
        check("pre_rst_mosi", MOSI, 0);
        RST = 1'b0;
        #1;
        check("arst_cs", CS, 1);
        check("arst_sclk", SCLK, 0);
        check("arst_mosi", MOSI, 1);
        check("arst_busy", busy, 0);
        startflag = 1'b0;
        tx_exp.delete();
        miso_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        s0 = n_ss;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_no_start", n_ss - s0, 0);
        tx_tbl[0] = 8'h55; rx_tbl[0] = 8'hFF;
        run_bytes(1);
        check("post_rst_one_byte", n_ss - s0, 1);

        repeat (5) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
